// File: rtl/iu_pkg.sv
// Shared constants and types for the warp issue unit.
package iu_pkg;

  localparam int NUM_WARPS_DEF = 8;
  localparam int WARP_ID_W_DEF = $clog2(NUM_WARPS_DEF);

  typedef logic [WARP_ID_W_DEF-1:0] warp_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first set request at or after i_start,
// wrapping modulo N (N need not be a power of two).
module rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [N-1:0]     o_grt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_vld
);

  localparam int SUM_W = IDX_W + 1;

  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic             w_found;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_wrapped;

  // Rotate right by i_start through a doubled copy so bit 0 is the start warp.
  assign w_rot = N'({i_req, i_req} >> i_start);

  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off   = IDX_W'(i);
        w_found = 1'b1;
      end
    end
  end

  assign w_sum     = {1'b0, i_start} + {1'b0, w_off};
  assign w_wrapped = (w_sum >= SUM_W'(N)) ? (w_sum - SUM_W'(N)) : w_sum;
  assign o_idx     = IDX_W'(w_wrapped);
  assign o_vld     = w_found;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign o_grt[gi] = w_found && (o_idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/warp_issue_unit.sv
// Warp issue unit: rotating issue grant, lowest-index exit grant, alive-mask tracking.
// Optional greedy-then-rotate issue policy when WARP_ISSUE_GREEDY_EN is defined.
module warp_issue_unit
  import iu_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_DEF,
  parameter int WARP_ID_W = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start_IU,
  input  logic [NUM_WARPS-1:0] WarpMask_Start_IU,
  input  logic [NUM_WARPS-1:0] Req_IB_IU,
  output logic [NUM_WARPS-1:0] Grt_IU_IB,
  input  logic [NUM_WARPS-1:0] Exit_Req_IB_IU,
  output logic [NUM_WARPS-1:0] Exit_Grt_IU_IB,
  output logic                 Valid_IU_OC,
  output logic [WARP_ID_W-1:0] WarpID_IU_OC,
  output logic [NUM_WARPS-1:0] ActiveWarps_IU,
  output logic                 Kernel_Done_IU
);

  logic [NUM_WARPS-1:0] r_active;
  logic [WARP_ID_W-1:0] r_ptr;
  logic                 r_valid;
  logic [WARP_ID_W-1:0] r_warp_id;
  logic                 r_done;

  logic [NUM_WARPS-1:0] w_elig;
  logic [NUM_WARPS-1:0] w_arb_grt;
  logic [WARP_ID_W-1:0] w_arb_idx;
  logic                 w_arb_vld;
  logic [NUM_WARPS-1:0] w_iss_grt;
  logic [WARP_ID_W-1:0] w_iss_idx;
  logic                 w_iss_vld;
  logic                 w_keep;
  logic                 w_adv;
  logic [WARP_ID_W-1:0] w_ptr_next;
  logic [NUM_WARPS-1:0] w_exit_elig;
  logic [NUM_WARPS-1:0] w_exit_grt;
  logic                 w_exit_vld;
  logic [NUM_WARPS-1:0] w_active_after_exit;
  logic                 w_launch;

  assign w_elig = Req_IB_IU & r_active;

  rr_arbiter #(
    .N     (NUM_WARPS),
    .IDX_W (WARP_ID_W)
  ) u_rr_arbiter (
    .i_req   (w_elig),
    .i_start (r_ptr),
    .o_grt   (w_arb_grt),
    .o_idx   (w_arb_idx),
    .o_vld   (w_arb_vld)
  );

`ifdef WARP_ISSUE_GREEDY_EN
  logic [WARP_ID_W-1:0] r_last;
  logic                 r_last_vld;
  logic [NUM_WARPS-1:0] w_last_oh;

  generate
    for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_last_oh
      assign w_last_oh[gi] = (r_last == WARP_ID_W'(gi));
    end
  endgenerate

  // Stick with the last-granted warp while it keeps requesting; the pointer stays put.
  assign w_keep    = r_last_vld && ((w_elig & w_last_oh) != '0);
  assign w_iss_grt = w_keep ? w_last_oh : w_arb_grt;
  assign w_iss_idx = w_keep ? r_last : w_arb_idx;
  assign w_iss_vld = w_keep || w_arb_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else if (w_iss_vld) begin
      r_last     <= w_iss_idx;
      r_last_vld <= 1'b1;
    end
  end
`else
  assign w_keep    = 1'b0;
  assign w_iss_grt = w_arb_grt;
  assign w_iss_idx = w_arb_idx;
  assign w_iss_vld = w_arb_vld;
`endif

  assign w_adv = w_arb_vld && !w_keep;

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_adv) begin
      w_ptr_next = (w_iss_idx == WARP_ID_W'(NUM_WARPS - 1)) ? '0
                                                            : w_iss_idx + WARP_ID_W'(1);
    end
  end

  assign Grt_IU_IB = rst ? '0 : w_iss_grt;

  // A warp issuing this cycle cannot also exit; issue has priority.
  assign w_exit_elig = Exit_Req_IB_IU & r_active & ~Grt_IU_IB;

  always_comb begin
    w_exit_grt = '0;
    w_exit_vld = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (w_exit_elig[i] && !w_exit_vld) begin
        w_exit_grt[i] = 1'b1;
        w_exit_vld    = 1'b1;
      end
    end
  end

  assign Exit_Grt_IU_IB      = rst ? '0 : w_exit_grt;
  assign w_active_after_exit = r_active & ~w_exit_grt;
  assign w_launch            = Start_IU && (r_active == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active  <= '0;
      r_ptr     <= '0;
      r_valid   <= 1'b0;
      r_warp_id <= '0;
      r_done    <= 1'b0;
    end else begin
      if (w_launch) begin
        r_active <= WarpMask_Start_IU;
        r_ptr    <= '0;
      end else begin
        r_active <= w_active_after_exit;
        r_ptr    <= w_ptr_next;
      end
      r_valid <= w_iss_vld;
      if (w_iss_vld) begin
        r_warp_id <= w_iss_idx;
      end
      r_done <= w_exit_vld && (w_active_after_exit == '0);
    end
  end

  assign Valid_IU_OC    = r_valid;
  assign WarpID_IU_OC   = r_warp_id;
  assign ActiveWarps_IU = r_active;
  assign Kernel_Done_IU = r_done;

endmodule

// File: tb/tb_warp_issue_unit.sv
// Directed self-checking bench for warp_issue_unit (8-warp and 6-warp instances).
module tb_warp_issue_unit;

  logic       clk;
  logic       rst;

  logic       start8;
  logic [7:0] mask8;
  logic [7:0] req8;
  logic [7:0] grt8;
  logic [7:0] exit_req8;
  logic [7:0] exit_grt8;
  logic       valid8;
  logic [2:0] id8;
  logic [7:0] active8;
  logic       done8;

  logic       start6;
  logic [5:0] mask6;
  logic [5:0] req6;
  logic [5:0] grt6;
  logic [5:0] exit_req6;
  logic [5:0] exit_grt6;
  logic       valid6;
  logic [2:0] id6;
  logic [5:0] active6;
  logic       done6;

  int n_checks;
  int n_errors;

  warp_issue_unit #(.NUM_WARPS(8)) u_dut (
    .clk               (clk),
    .rst               (rst),
    .Start_IU          (start8),
    .WarpMask_Start_IU (mask8),
    .Req_IB_IU         (req8),
    .Grt_IU_IB         (grt8),
    .Exit_Req_IB_IU    (exit_req8),
    .Exit_Grt_IU_IB    (exit_grt8),
    .Valid_IU_OC       (valid8),
    .WarpID_IU_OC      (id8),
    .ActiveWarps_IU    (active8),
    .Kernel_Done_IU    (done8)
  );

  warp_issue_unit #(.NUM_WARPS(6)) u_dut6 (
    .clk               (clk),
    .rst               (rst),
    .Start_IU          (start6),
    .WarpMask_Start_IU (mask6),
    .Req_IB_IU         (req6),
    .Grt_IU_IB         (grt6),
    .Exit_Req_IB_IU    (exit_req6),
    .Exit_Grt_IU_IB    (exit_grt6),
    .Valid_IU_OC       (valid6),
    .WarpID_IU_OC      (id6),
    .ActiveWarps_IU    (active6),
    .Kernel_Done_IU    (done6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    start8    = 1'b0;
    mask8     = '0;
    req8      = '0;
    exit_req8 = '0;
    start6    = 1'b0;
    mask6     = '0;
    req6      = '0;
    exit_req6 = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_active", active8, 8'h00);
    check("rst_valid", valid8, 1'b0);
    check("rst_id", id8, 3'd0);
    check("rst_done", done8, 1'b0);

    // 6-warp instance: w5 then wrap to w0, never index 6/7
    start6 = 1'b1;
    mask6  = 6'h3F;
    step();
    start6 = 1'b0;
    req6   = 6'h20;
    #1;
    check("n6_grt_w5", grt6, 6'h20);
    step();
    $display("n6 issue: valid=%0b id=%0d", valid6, id6);
    check("n6_id_w5", id6, 3'd5);
    req6 = 6'h21;
    #1;
    check("n6_grt_wrap_w0", grt6, 6'h01);
    step();
    $display("n6 issue: valid=%0b id=%0d", valid6, id6);
    check("n6_id_w0", id6, 3'd0);
    req6 = 6'h20;
    #1;
    check("n6_grt_w5_again", grt6, 6'h20);
    req6 = '0;

    // Launch coincident with requests: nothing granted yet
    start8 = 1'b1;
    mask8  = 8'hFF;
    req8   = 8'hFF;
    #1;
    check("launch_no_grant", grt8, 8'h00);
    step();
    start8 = 1'b0;
    check("launch_active", active8, 8'hFF);
    check("launch_valid", valid8, 1'b0);

    // Round-robin over all warps, wrapping 7 -> 0
    for (int k = 0; k < 10; k++) begin
      #1;
      check("rr_grant", grt8, 32'd1 << (k % 8));
      step();
      $display("rr issue %0d: valid=%0b id=%0d", k, valid8, id8);
      check("rr_valid", valid8, 1'b1);
      check("rr_id", id8, k % 8);
    end

    // Reset during active issue
    rst = 1'b1;
    #1;
    check("rst_mid_grt", grt8, 8'h00);
    step();
    check("rst_mid_active", active8, 8'h00);
    check("rst_mid_valid", valid8, 1'b0);
    check("rst_mid_id", id8, 3'd0);
    check("rst_hold_grt", grt8, 8'h00);
    step();
    rst  = 1'b0;
    req8 = '0;

    // Requests only from inactive warps
    start8 = 1'b1;
    mask8  = 8'h0F;
    step();
    start8 = 1'b0;
    check("mask0f_active", active8, 8'h0F);
    req8 = 8'hF0;
    #1;
    check("inactive_grt", grt8, 8'h00);
    step();
    check("inactive_valid", valid8, 1'b0);
    req8 = 8'h0A;
    #1;
    check("ptr_unmoved_w1", grt8, 8'h02);
    step();

    // Issue beats exit on the same warp
    req8      = 8'h04;
    exit_req8 = 8'h0C;
    #1;
    check("both_grt", grt8, 8'h04);
    check("both_exit_grt", exit_grt8, 8'h08);
    step();
    $display("issue+exit: valid=%0b id=%0d active=%h", valid8, id8, active8);
    check("both_active", active8, 8'h07);
    check("both_id", id8, 3'd2);
    req8      = '0;
    exit_req8 = 8'h04;
    #1;
    check("exit_w2", exit_grt8, 8'h04);
    step();
    check("exit_w2_active", active8, 8'h03);
    check("exit_w2_done", done8, 1'b0);
    check("idle_valid", valid8, 1'b0);
    check("idle_id_hold", id8, 3'd2);

    // Exit w0 then w1 with a coincident (ignored) start
    exit_req8 = 8'h01;
    #1;
    check("exit_w0", exit_grt8, 8'h01);
    step();
    check("exit_w0_done", done8, 1'b0);
    exit_req8 = 8'h02;
    start8    = 1'b1;
    mask8     = 8'h01;
    #1;
    check("exit_w1", exit_grt8, 8'h02);
    step();
    $display("final exit: active=%h done=%0b", active8, done8);
    check("final_active", active8, 8'h00);
    check("done_pulse", done8, 1'b1);
    exit_req8 = '0;
    step();
    check("done_one_cycle", done8, 1'b0);
    check("relaunch_active", active8, 8'h01);
    start8 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
